rx_char_fifo: RTL and testbench

- Buffering stage directly downstream of the serial Receive block on the lab5 DE1_SoC board.
- Captures each 8-bit character that the receiver presents on its parallel output, signalled by its char-received level.
- Queues characters in a small FIFO. The Nios CPU drains the FIFO through PIO ports using a level/edge acknowledge handshake.
- Decouples the slow serial link (slow_clocks[7] domain logic, sampled in the 50 MHz domain) from CPU polling latency, and flags lost characters.

---
 rtl/rx_fifo_pkg.sv | 9 +
 rtl/rise_detect.sv | 22 ++
 rtl/rx_char_fifo.sv | 113 +++++++++++
 tb/tb_rx_char_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared defaults and types for the receive-side character FIFO.
package rx_fifo_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 16;

    typedef logic [7:0] char_t;

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a level input.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // History resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/rx_char_fifo.sv
// Character FIFO between the serial receiver and the CPU's PIO polling loop,
// with a sticky overflow flag for characters dropped while full.
module rx_char_fifo
    import rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_received,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              cpu_ack,
    input  logic              clear_overflow,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);

    logic              push_evt;
    logic              pop_evt;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic              empty;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    rise_detect u_push_detect (
        .clock (clock),
        .reset (reset),
        .level (char_received),
        .pulse (push_evt)
    );

    rise_detect u_pop_detect (
        .clock (clock),
        .reset (reset),
        .level (cpu_ack),
        .pulse (pop_evt)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == CountFull);

    // A pop frees the slot a same-cycle push needs, so full + pop never drops.
    assign do_pop  = pop_evt & ~empty;
    assign do_push = push_evt & (~full | do_pop);
    assign drop    = push_evt & full & ~pop_evt;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left uncleared on reset; the count mask hides stale entries.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= parallel_in;
        end
    end

    assign data_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign data_valid = ~empty;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rx_char_fifo.sv
// Self-checking bench for rx_char_fifo: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_rx_char_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       char_received = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic       cpu_ack = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       full;
    logic       overflow;

    always #5 clock = ~clock;

    rx_char_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .char_received  (char_received),
        .parallel_in    (parallel_in),
        .cpu_ack        (cpu_ack),
        .clear_overflow (clear_overflow),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .count          (count),
        .full           (full),
        .overflow       (overflow)
    );

    // ctl = {reset, char_received, cpu_ack, clear_overflow}; flags = {valid, full, overflow}
    typedef struct packed {
        logic [3:0] ctl;
        logic [7:0] pin;
        logic [7:0] e_dout;
        logic [4:0] e_count;
        logic [2:0] e_flags;
    } vec_t;

    localparam int NumVecs = 20;
    vec_t vecs [NumVecs];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mq [$];
    logic       m_ovf;
    logic       m_pcr;
    logic       m_pack;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        char_received = 1'b0;
        cpu_ack = 1'b0;
        clear_overflow = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [7:0] c);
        char_received = 1'b1;
        parallel_in = c;
        tick();
        char_received = 1'b0;
        tick();
    endtask

    task automatic pop();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        tick();
    endtask

    task automatic model_step(input logic rst, input logic cr, input logic [7:0] pin,
                              input logic ack, input logic clr);
        logic pe, po, drop;
        int   sz;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_pcr  = 1'b1;
            m_pack = 1'b1;
        end else begin
            pe   = cr & ~m_pcr;
            po   = ack & ~m_pack;
            sz   = mq.size();
            drop = pe && (sz == 16) && !po;
            if (po && sz > 0) void'(mq.pop_front());
            if (pe && !drop) mq.push_back(pin);
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_pcr  = cr;
            m_pack = ack;
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1100, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[1]  = '{4'b1100, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[2]  = '{4'b0100, 8'h41, 8'h00, 5'd0, 3'b000};
        vecs[3]  = '{4'b0000, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[4]  = '{4'b0100, 8'h41, 8'h41, 5'd1, 3'b100};
        vecs[5]  = '{4'b0000, 8'h00, 8'h41, 5'd1, 3'b100};
        vecs[6]  = '{4'b0010, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[7]  = '{4'b0000, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[8]  = '{4'b0100, 8'h48, 8'h48, 5'd1, 3'b100};
        vecs[9]  = '{4'b0000, 8'h00, 8'h48, 5'd1, 3'b100};
        vecs[10] = '{4'b0100, 8'h49, 8'h48, 5'd2, 3'b100};
        vecs[11] = '{4'b0000, 8'h00, 8'h48, 5'd2, 3'b100};
        vecs[12] = '{4'b0010, 8'h00, 8'h49, 5'd1, 3'b100};
        vecs[13] = '{4'b0000, 8'h00, 8'h49, 5'd1, 3'b100};
        vecs[14] = '{4'b0010, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[15] = '{4'b0000, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[16] = '{4'b0010, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[17] = '{4'b0001, 8'h00, 8'h00, 5'd0, 3'b000};
        vecs[18] = '{4'b0110, 8'h50, 8'h50, 5'd1, 3'b100};
        vecs[19] = '{4'b0000, 8'h00, 8'h50, 5'd1, 3'b100};

        // Table: reset with char_received held, first push, pops, pop on empty
        for (int i = 0; i < NumVecs; i++) begin
            {reset, char_received, cpu_ack, clear_overflow} = vecs[i].ctl;
            parallel_in = vecs[i].pin;
            tick();
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d flags", i), 32'({data_valid, full, overflow}),
                  32'(vecs[i].e_flags));
        end

        // Fill, drop with clear_overflow high (set wins), drain in order, clear
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill full", 32'(full), 32'd1);
        check("fill count", 32'(count), 32'd16);
        check("fill head", 32'(data_out), 32'h00);
        char_received = 1'b1;
        parallel_in = 8'hFF;
        clear_overflow = 1'b1;
        tick();
        check("drop set-wins overflow", 32'(overflow), 32'd1);
        check("drop count", 32'(count), 32'd16);
        char_received = 1'b0;
        clear_overflow = 1'b0;
        tick();
        check("overflow sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain %0d", i), 32'(data_out), 32'(i));
            pop();
        end
        check("drained count", 32'(count), 32'd0);
        check("drained valid", 32'(data_valid), 32'd0);
        check("drained data_out", 32'(data_out), 32'd0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("overflow cleared", 32'(overflow), 32'd0);

        // Reset mid-stream with data and overflow pending
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        push(8'hFF);
        for (int i = 0; i < 11; i++) pop();
        check("pre-reset count", 32'(count), 32'd5);
        check("pre-reset overflow", 32'(overflow), 32'd1);
        check("pre-reset head", 32'(data_out), 32'h6B);
        reset = 1'b1;
        tick();
        check("reset count", 32'(count), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset valid", 32'(data_valid), 32'd0);
        reset = 1'b0;
        tick();
        push(8'h7A);
        check("post-reset head", 32'(data_out), 32'h7A);
        check("post-reset count", 32'(count), 32'd1);

        // Pointer wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        check("wrap full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap out %0d", i), 32'(data_out), 32'(8'h20 + i));
            pop();
        end
        check("wrap overflow", 32'(overflow), 32'd0);
        check("wrap empty", 32'(count), 32'd0);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        char_received = 1'b1;
        cpu_ack = 1'b1;
        parallel_in = 8'h55;
        tick();
        char_received = 1'b0;
        cpu_ack = 1'b0;
        check("simul count", 32'(count), 32'd16);
        check("simul overflow", 32'(overflow), 32'd0);
        check("simul head", 32'(data_out), 32'h31);
        tick();
        for (int i = 1; i < 16; i++) pop();
        check("simul last", 32'(data_out), 32'h55);
        pop();
        pop();
        check("pop empty count", 32'(count), 32'd0);
        check("pop empty overflow", 32'(overflow), 32'd0);
        check("pop empty valid", 32'(data_valid), 32'd0);

        // Randomized traffic against the queue model
        do_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_pcr  = 1'b0;
        m_pack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            char_received  = 1'($urandom_range(0, 1));
            parallel_in    = 8'($urandom);
            cpu_ack        = ($urandom_range(0, 9) < (((i / 250) % 2 == 1) ? 6 : 1));
            clear_overflow = ($urandom_range(0, 15) == 0);
            tick();
            model_step(reset, char_received, parallel_in, cpu_ack, clear_overflow);
            check("rand count", 32'(count), 32'(mq.size()));
            check("rand data_out", 32'(data_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            check("rand valid", 32'(data_valid), 32'(mq.size() > 0));
            check("rand full", 32'(full), 32'(mq.size() == 16));
            check("rand overflow", 32'(overflow), 32'(m_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
